// File: rtl/music_pkg.sv
// music_pkg: note period table, tune codes and recorder FSM encoding
package music_pkg;
  localparam int NUM_NOTES = 21;
  localparam logic [7:0] TUNE_REST = 8'h00;
  localparam logic [7:0] TUNE_INVALID = 8'hFF;
  localparam logic [11:0] END_MARKER = 12'h000;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_TONE = 3'd2;
  localparam logic [2:0] S_REST = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  // 50 MHz full-period counts, low do..ti, mid do..ti, high do..ti
  localparam logic [19:0] PERIODS [NUM_NOTES] = '{
    20'd382226, 20'd340524, 20'd303372, 20'd286346, 20'd255104, 20'd227273, 20'd202477,
    20'd191113, 20'd170262, 20'd151686, 20'd143173, 20'd127552, 20'd113636, 20'd101238,
    20'd95556,  20'd85131,  20'd75843,  20'd71586,  20'd63776,  20'd56818,  20'd50619
  };
  function automatic logic [7:0] tune_code(input int k);
    return {4'(k / 7 + 1), 4'(k % 7 + 1)};
  endfunction
endpackage

// File: rtl/period_to_tune.sv
// period_to_tune: window-compares a measured period against the note table
module period_to_tune
  import music_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [19:0] period,
  output logic [7:0]  tune
);
  logic [NUM_NOTES-1:0] hit;
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_cmp
    localparam logic [19:0] P = PERIODS[i] >> SHIFT;
    localparam logic [19:0] T = P >> 6;
    assign hit[i] = period >= P - T && period <= P + T;
  end
  always_comb begin
    tune = TUNE_INVALID;
    for (int i = 0; i < NUM_NOTES; i++) tune = hit[i] ? tune_code(i) : tune;
  end
endmodule

// File: rtl/music_note_recorder.sv
// music_note_recorder: measures a square-wave tone and records {tune, beat} words into a note RAM
module music_note_recorder
  import music_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int BEAT_UNIT = 3125000,
  parameter int SILENCE_TIMEOUT = 1048576,
  parameter int TONE_SCALE_SHIFT = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  tone_in,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] note_cnt,
  output logic                  rec_done,
  output logic                  overflow
);
  localparam int UW = $clog2(BEAT_UNIT + 1);
  localparam logic [UW-1:0] WRAP_AT = UW'(BEAT_UNIT - 1);
  localparam logic [UW-1:0] HALF = UW'(BEAT_UNIT / 2);
  localparam logic [UW-1:0] TO_U = UW'(SILENCE_TIMEOUT % BEAT_UNIT);
  localparam logic [3:0] TO_B = 4'(SILENCE_TIMEOUT / BEAT_UNIT);
  localparam logic [19:0] TO_CNT = 20'(SILENCE_TIMEOUT - 1);

  logic [2:0] sync, state;
  logic [19:0] per_cnt;
  logic [7:0] code, prev, cur;
  logic [UW-1:0] unit_cnt, snap_unit;
  logic [3:0] beats, snap_beats, rnd, snap_rnd, pend;
  logic [ADDR_WIDTH-1:0] na;
  logic en_q, is_note, rise, go, fall, active, conf, wrap, split, tmo, note_req, full, mark_req;

  function automatic logic [3:0] round_beats(input logic [3:0] b, input logic [UW-1:0] u);
    return b + 4'(u >= HALF);
  endfunction

  period_to_tune #(.SHIFT(TONE_SCALE_SHIFT)) u_dec (.period(per_cnt), .tune(code));

  assign rise = sync[1] & ~sync[2];
  assign go = en & ~en_q;
  assign fall = en_q & ~en;
  assign active = state == S_ARMED || state == S_TONE || state == S_REST;
  assign conf = active && rise && code != TUNE_INVALID && code == prev && code != cur;
  assign tmo = state == S_TONE && !rise && per_cnt == TO_CNT;
  assign wrap = unit_cnt == WRAP_AT;
  assign split = (state == S_TONE || state == S_REST) && wrap && beats == 4'd14 && !conf && !tmo;
  assign rnd = round_beats(beats, unit_cnt);
  assign snap_rnd = round_beats(snap_beats, snap_unit);
  assign pend = tmo ? snap_rnd : rnd;
  // a note lands one address past any note still being written this cycle
  assign na = wr_addr + ADDR_WIDTH'(wr_en & is_note);
  assign note_req = split | ((conf | tmo | state == S_FLUSH) & cur != TUNE_INVALID & pend != 4'd0);
  assign full = note_req & (na == {ADDR_WIDTH{1'b1}});
  assign mark_req = full | (state == S_FLUSH && cur == TUNE_INVALID);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
      en_q <= en;
      per_cnt <= '0;
      unit_cnt <= '0;
      beats <= '0;
      snap_unit <= '0;
      snap_beats <= '0;
      prev <= TUNE_INVALID;
      cur <= TUNE_INVALID;
      state <= S_IDLE;
      wr_en <= 1'b0;
      is_note <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      note_cnt <= '0;
      rec_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync <= {sync[1:0], tone_in};
      en_q <= en;
      per_cnt <= rise ? 20'd1 : per_cnt + 20'(per_cnt != '1);
      unit_cnt <= wrap ? '0 : unit_cnt + 1'b1;
      beats <= beats + 4'(wrap);
      if (rise) {snap_beats, snap_unit} <= {beats, unit_cnt};
      if (rise && code != TUNE_INVALID) prev <= code;
      wr_en <= note_req | mark_req;
      is_note <= note_req & ~full;
      if (note_req | mark_req) wr_data <= mark_req ? END_MARKER : {cur, split ? 4'hF : pend};
      if (wr_en && is_note) begin
        wr_addr <= wr_addr + 1'b1;
        note_cnt <= note_cnt + 1'b1;
      end
      rec_done <= wr_en & ~is_note;
      if (state == S_IDLE) begin
        if (go) begin
          state <= S_ARMED;
          wr_addr <= '0;
          note_cnt <= '0;
          overflow <= 1'b0;
          cur <= TUNE_INVALID;
          prev <= TUNE_INVALID;
        end
      end else if (state == S_FLUSH) begin
        cur <= TUNE_INVALID;
        if (cur == TUNE_INVALID || full) state <= S_IDLE;
        if (full) overflow <= 1'b1;
      end else begin
        if (conf) begin
          cur <= code;
          state <= S_TONE;
          unit_cnt <= '0;
          beats <= '0;
          {snap_beats, snap_unit} <= '0;
        end else if (split) begin
          unit_cnt <= '0;
          beats <= '0;
          {snap_beats, snap_unit} <= '0;
        end else if (tmo) begin
          cur <= TUNE_REST;
          prev <= TUNE_INVALID;
          unit_cnt <= TO_U;
          beats <= TO_B;
          state <= S_REST;
        end
        if (fall) state <= S_FLUSH;
        if (full) begin
          state <= S_IDLE;
          overflow <= 1'b1;
          cur <= TUNE_INVALID;
        end
      end
    end
  end
endmodule

// File: tb/tb_music_note_recorder.sv
// tb_music_note_recorder: directed takes with hand-computed note words
module tb_music_note_recorder;
  localparam int LA = 110, DO = 186, STRAY = 156;
  logic CLK = 1'b0, RST = 1'b1, en = 1'b0, tone_in = 1'b0;
  logic wr_en, rec_done, overflow;
  logic [3:0] wr_addr, note_cnt;
  logic [11:0] wr_data;
  int n_chk = 0, n_fail = 0, done_n = 0;
  logic [3:0] qa[$];
  logic [11:0] qd[$];
  logic [11:0] w[$];

  always #5 CLK = ~CLK;

  music_note_recorder #(
    .ADDR_WIDTH(4), .BEAT_UNIT(1250), .SILENCE_TIMEOUT(256), .TONE_SCALE_SHIFT(10)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .tone_in(tone_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .note_cnt(note_cnt), .rec_done(rec_done), .overflow(overflow)
  );

  always @(negedge CLK) begin
    if (wr_en) begin
      qa.push_back(wr_addr);
      qd.push_back(wr_data);
    end
    if (rec_done) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tone(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      cyc(p / 2);
      tone_in = 1'b0;
      cyc(p - p / 2);
    end
  endtask

  task automatic start_take;
    qa.delete();
    qd.delete();
    done_n = 0;
    en = 1'b1;
    cyc(10);
  endtask

  task automatic end_take;
    cyc(3);
    en = 1'b0;
    cyc(40);
  endtask

  task automatic expect_take(input string tag);
    chk({tag, " words"}, qa.size(), w.size());
    for (int i = 0; i < w.size() && i < qa.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), qa[i], i);
      chk($sformatf("%s data[%0d]", tag, i), qd[i], w[i]);
    end
    chk({tag, " rec_done"}, done_n, 1);
  endtask

  initial begin
    cyc(3);
    RST = 1'b0;
    cyc(1);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst note_cnt", note_cnt, 0);
    chk("rst rec_done", rec_done, 0);
    chk("rst overflow", overflow, 0);
    cyc(1000);

    start_take;
    tone(LA, 34);
    end_take;
    w = '{12'h263, 12'h000};
    expect_take("single");
    chk("single note_cnt", note_cnt, 1);
    chk("single overflow", overflow, 0);
    cyc(1000);

    start_take;
    tone(LA, 22);
    tone(STRAY, 1);
    tone(DO, 7);
    end_take;
    w = '{12'h262, 12'h211, 12'h000};
    expect_take("change");
    chk("change note_cnt", note_cnt, 2);
    cyc(1000);

    start_take;
    tone(LA, 25);
    cyc(2500);
    tone(LA, 14);
    end_take;
    w = '{12'h262, 12'h002, 12'h261, 12'h000};
    expect_take("rest");
    cyc(1000);

    start_take;
    tone(LA, 228);
    end_take;
    w = '{12'h26F, 12'h265, 12'h000};
    expect_take("long");
    cyc(1000);

    start_take;
    repeat (10) begin
      tone(LA, 10);
      tone(DO, 6);
    end
    end_take;
    w.delete();
    for (int i = 0; i < 15; i++) w.push_back(i % 2 ? 12'h211 : 12'h261);
    w.push_back(12'h000);
    expect_take("full");
    chk("full overflow", overflow, 1);
    chk("full note_cnt", note_cnt, 15);
    cyc(1000);

    start_take;
    fork
      begin
        tone(LA, 12);
        tone(DO, 10);
      end
      begin
        cyc(12 * LA + 1000);
        chk("rst mid words", qd.size(), 1);
        if (qd.size() > 0) chk("rst mid data", qd[0], 12'h261);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("rst mid wr_en", wr_en, 0);
        chk("rst mid wr_addr", wr_addr, 0);
        chk("rst mid wr_data", wr_data, 0);
        chk("rst mid note_cnt", note_cnt, 0);
        chk("rst mid rec_done", rec_done, 0);
        chk("rst mid overflow", overflow, 0);
        qa.delete();
        qd.delete();
      end
    join
    en = 1'b0;
    cyc(300);
    chk("rst mid no writes", qa.size(), 0);
    chk("rst mid no done", done_n, 0);
    cyc(1000);

    start_take;
    tone(LA, 34);
    end_take;
    w = '{12'h263, 12'h000};
    expect_take("retake");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
